test_access_ctrl: RTL and testbench

Parametrised test-access controller for the transceiver datapath; successor to the fixed top-level debug mux/demux tree. It sits between the chip test pins and N_CH internal channels (FIFO, modulator, decoder, CORDIC and CDR nodes), each DATA_W bits wide. The block is configured through a serial shift/update register and provides:
- one injection path: a test-pin value overrides one channel;
- one registered observation path: one channel is routed to the test pins;
- an optional triggered capture engine with programmable delay.

---
 rtl/test_access_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_test_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_access_ctrl.sv
// -----------------------------------------------------------------------------
// test_access_ctrl
//
// Test-access controller between the chip test pins and N_CH internal channels.
// A serial shadow register is shifted LSB-first and copied into the active
// configuration on update. The active configuration controls:
//   - an injection path: the test-pin value overrides one channel driver,
//   - a registered observation path: one channel is routed to the test pins,
//   - an optional triggered capture engine with a programmable delay.
//
// Config word: {dly[DLY_W-1:0], inj_en, inj_sel[SEL_W-1:0], obs_sel[SEL_W-1:0]}
//
// Build option: define TAP_CAPTURE_EN to include the capture engine. When it
// is undefined the capture outputs are tied to zero, inArm/inTrig/inCapAck are
// ignored, and the dly field is stored but unused.
//
// Ports:
//   inClock      clock, rising edge
//   inReset      asynchronous active-low reset
//   inCfgData    serial config bit
//   inCfgShift   shift enable for the shadow register
//   inCfgUpdate  copy shadow to active config
//   outCfgData   serial readback (shadow bit 0)
//   inFuncBus    functional channel drivers, lane k = [k*DATA_W +: DATA_W]
//   outInjBus    channel drivers toward consumers (with optional override)
//   inInjData    test-pin injection value
//   inObsBus     observable channel values
//   outObsData   registered observed lane
//   inArm        arm the capture engine
//   inTrig       capture trigger, level-sampled
//   inCapAck     release a held capture
//   outCapData   captured value
//   outCapValid  capture held
//   outBusy      capture engine not idle
// -----------------------------------------------------------------------------
module test_access_ctrl #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 4,
  parameter int DLY_W  = 4
) (
  input  logic                     inClock,
  input  logic                     inReset,
  input  logic                     inCfgData,
  input  logic                     inCfgShift,
  input  logic                     inCfgUpdate,
  output logic                     outCfgData,
  input  logic [N_CH*DATA_W-1:0]   inFuncBus,
  output logic [N_CH*DATA_W-1:0]   outInjBus,
  input  logic [DATA_W-1:0]        inInjData,
  input  logic [N_CH*DATA_W-1:0]   inObsBus,
  output logic [DATA_W-1:0]        outObsData,
  input  logic                     inArm,
  input  logic                     inTrig,
  input  logic                     inCapAck,
  output logic [DATA_W-1:0]        outCapData,
  output logic                     outCapValid,
  output logic                     outBusy
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int CFG_W = DLY_W + 1 + 2 * SEL_W;

  // ---------------------------------------------------------------------------
  // Configuration: shadow shift register and active copy
  // ---------------------------------------------------------------------------
  logic [CFG_W-1:0] shadow_q, shadow_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;

  always_comb begin
    shadow_d = shadow_q;
    cfg_d    = cfg_q;
    if (inCfgShift) begin
      shadow_d = {inCfgData, shadow_q[CFG_W-1:1]};
    end
    // Copies the registered shadow, so a simultaneous shift is not seen here.
    if (inCfgUpdate) begin
      cfg_d = shadow_q;
    end
  end

  logic [SEL_W-1:0] obs_sel;
  logic [SEL_W-1:0] inj_sel;
  logic             inj_en;
  logic [DLY_W-1:0] dly;

  assign obs_sel = cfg_q[SEL_W-1:0];
  assign inj_sel = cfg_q[2*SEL_W-1:SEL_W];
  assign inj_en  = cfg_q[2*SEL_W];
  assign dly     = cfg_q[CFG_W-1:2*SEL_W+1];

  assign outCfgData = shadow_q[0];

  // ---------------------------------------------------------------------------
  // Injection path: per-lane override, combinational
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_inj
      localparam logic [SEL_W-1:0] LANE = SEL_W'(gi);
      assign outInjBus[gi*DATA_W +: DATA_W] =
        (inj_en && (inj_sel == LANE)) ? inInjData : inFuncBus[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Observation lane mux. A select with no matching lane (>= N_CH) yields 0.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] obs_lane;

  always_comb begin
    obs_lane = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (obs_sel == SEL_W'(k)) begin
        obs_lane = inObsBus[k*DATA_W +: DATA_W];
      end
    end
  end

  logic [DATA_W-1:0] obs_q;

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      shadow_q <= '0;
      cfg_q    <= '0;
      obs_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cfg_q    <= cfg_d;
      obs_q    <= obs_lane;
    end
  end

  assign outObsData = obs_q;

`ifdef TAP_CAPTURE_EN
  // ---------------------------------------------------------------------------
  // Capture engine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DELAY = 2'd2,
    HOLD  = 2'd3
  } cap_state_e;

  cap_state_e        state_q, state_d;
  logic [DLY_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cap_q, cap_d;

  always_ff @(posedge inClock or negedge inReset) begin
    if (!inReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    unique case (state_q)
      IDLE: begin
        if (inArm) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        // dly is latched here; later config updates do not change the delay.
        if (inTrig) begin
          state_d = DELAY;
          cnt_d   = dly;
        end
      end
      DELAY: begin
        // obs_sel is read live so an update during the delay steers the capture.
        if (cnt_q == '0) begin
          cap_d   = obs_lane;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (inCapAck) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign outCapData  = cap_q;
  assign outCapValid = (state_q == HOLD);
  assign outBusy     = (state_q != IDLE);
`else
  // Capture engine absent: control inputs and the dly field are deliberately
  // left without a load.
  logic unused_capture;
  assign unused_capture = ^{inArm, inTrig, inCapAck, dly};

  assign outCapData  = '0;
  assign outCapValid = 1'b0;
  assign outBusy     = 1'b0;
`endif

endmodule

// File: tb/tb_test_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_test_access_ctrl
//
// Directed, table-driven bench for test_access_ctrl (N_CH=8, DATA_W=4,
// DLY_W=4, CFG_W=11). Inject/observe vectors come from a record table; the
// config, reset and capture corner cases are hand-written sequences. Capture
// expectations follow the TAP_CAPTURE_EN build setting.
// -----------------------------------------------------------------------------
module tb_test_access_ctrl;

  localparam int N_CH   = 8;
  localparam int DATA_W = 4;
  localparam int DLY_W  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_data, cfg_shift, cfg_update;
  logic        cfg_out;
  logic [31:0] func_bus, inj_bus, obs_bus;
  logic [3:0]  inj_data, obs_data, cap_data;
  logic        arm, trig, cap_ack, cap_valid, busy;

  int n_cmp = 0;
  int n_err = 0;

  test_access_ctrl #(.N_CH(N_CH), .DATA_W(DATA_W), .DLY_W(DLY_W)) dut (
    .inClock     (clk),
    .inReset     (rst_n),
    .inCfgData   (cfg_data),
    .inCfgShift  (cfg_shift),
    .inCfgUpdate (cfg_update),
    .outCfgData  (cfg_out),
    .inFuncBus   (func_bus),
    .outInjBus   (inj_bus),
    .inInjData   (inj_data),
    .inObsBus    (obs_bus),
    .outObsData  (obs_data),
    .inArm       (arm),
    .inTrig      (trig),
    .inCapAck    (cap_ack),
    .outCapData  (cap_data),
    .outCapValid (cap_valid),
    .outBusy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        inj_en;
    logic [2:0]  inj_sel;
    logic [2:0]  obs_sel;
    logic [3:0]  inj_data;
    logic [31:0] func_bus;
    logic [31:0] obs_bus;
    logic [31:0] exp_inj;
    logic [3:0]  exp_obs;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk_cfg(input logic [3:0] d, input logic en,
                                         input logic [2:0] is, input logic [2:0] os);
    return {d, en, is, os};
  endfunction

  task automatic shift_only(input logic [10:0] w);
    for (int i = 0; i < 11; i++) begin
      cfg_data  = w[i];
      cfg_shift = 1'b1;
      tick();
    end
    cfg_shift = 1'b0;
    cfg_data  = 1'b0;
  endtask

  task automatic update_only();
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  task automatic load_cfg(input logic [10:0] w);
    shift_only(w);
    update_only();
  endtask

  initial begin
    // Reset and idle inputs
    rst_n = 1'b0; cfg_data = 1'b0; cfg_shift = 1'b0; cfg_update = 1'b0;
    func_bus = 32'h7654_3210; obs_bus = 32'hFEDC_BA98; inj_data = 4'hF;
    arm = 1'b0; trig = 1'b0; cap_ack = 1'b0;

    vecs[0] = '{1'b1, 3'd2, 3'd5, 4'h7, 32'h7654_3210, 32'hFEDC_BA98, 32'h7654_3710, 4'hD};
    vecs[1] = '{1'b1, 3'd7, 3'd0, 4'hC, 32'h7654_3210, 32'hFEDC_BA98, 32'hC654_3210, 4'h8};
    vecs[2] = '{1'b0, 3'd7, 3'd7, 4'hC, 32'h7654_3210, 32'hFEDC_BA98, 32'h7654_3210, 4'hF};
    vecs[3] = '{1'b1, 3'd0, 3'd3, 4'h5, 32'h1111_1111, 32'h0000_A000, 32'h1111_1115, 4'hA};
    vecs[4] = '{1'b0, 3'd2, 3'd1, 4'hF, 32'hAAAA_AAAA, 32'h1234_5678, 32'hAAAA_AAAA, 4'h7};

    #1;
    chk("rst_inj_bus", inj_bus, 32'h7654_3210);
    chk("rst_obs", {28'd0, obs_data}, 32'd0);
    chk("rst_cap_data", {28'd0, cap_data}, 32'd0);
    chk("rst_flags", {29'd0, cfg_out, cap_valid, busy}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Shift ones: the first one reaches shadow bit 0 on the 11th shift edge.
    cfg_data  = 1'b1;
    cfg_shift = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("cfg_out_after10", {31'd0, cfg_out}, 32'd0);
    tick();
    chk("cfg_out_after11", {31'd0, cfg_out}, 32'd1);
    cfg_shift = 1'b0;
    cfg_data  = 1'b0;
    chk("no_update_inj", inj_bus, 32'h7654_3210);

    // Table-driven inject/observe vectors
    foreach (vecs[v]) begin
      load_cfg(mk_cfg(4'd0, vecs[v].inj_en, vecs[v].inj_sel, vecs[v].obs_sel));
      func_bus = vecs[v].func_bus;
      obs_bus  = vecs[v].obs_bus;
      inj_data = vecs[v].inj_data;
      #1;
      chk($sformatf("vec%0d_inj", v), inj_bus, vecs[v].exp_inj);
      tick();
      chk($sformatf("vec%0d_obs", v), {28'd0, obs_data}, {28'd0, vecs[v].exp_obs});
    end

    // Observe latency and select held until update
    load_cfg(mk_cfg(4'd0, 1'b0, 3'd0, 3'd5));
    obs_bus = 32'h0000_0000;
    tick();
    obs_bus = 32'h00A0_0300;  // lane5=A, lane2=3
    #1;
    chk("obs_before_edge", {28'd0, obs_data}, 32'h0);
    tick();
    chk("obs_lat1", {28'd0, obs_data}, 32'hA);
    shift_only(mk_cfg(4'd0, 1'b0, 3'd0, 3'd2));
    chk("obs_sel_held", {28'd0, obs_data}, 32'hA);
    update_only();
    chk("obs_update_edge", {28'd0, obs_data}, 32'hA);
    tick();
    chk("obs_new_sel", {28'd0, obs_data}, 32'h3);

    // Same-cycle shift+update loads the pre-shift shadow (inj_en=1, sel=4)
    func_bus = 32'h7654_3210;
    inj_data = 4'hE;
    shift_only(mk_cfg(4'd0, 1'b1, 3'd4, 3'd0));
    cfg_data = 1'b1; cfg_shift = 1'b1; cfg_update = 1'b1;
    tick();
    cfg_data = 1'b0; cfg_shift = 1'b0; cfg_update = 1'b0;
    chk("shift_upd_same", inj_bus, 32'h765E_3210);

`ifdef TAP_CAPTURE_EN
    // dly=3, obs_sel=1: capture at t+4
    load_cfg(mk_cfg(4'd3, 1'b0, 3'd0, 3'd1));
    obs_bus = 32'h0000_0090;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("armed_busy", {30'd0, busy, cap_valid}, 32'h2);
    trig = 1'b1; tick(); trig = 1'b0;          // edge t
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) obs_bus = 32'h0000_0030;
      tick();
      chk($sformatf("dly3_wait_t%0d", i), {30'd0, busy, cap_valid}, 32'h2);
    end
    tick();                                     // edge t+4
    chk("dly3_valid", {31'd0, cap_valid}, 32'd1);
    chk("dly3_data", {28'd0, cap_data}, 32'h3);
    obs_bus = 32'h0000_0050;
    trig = 1'b1;
    tick(); tick();
    trig = 1'b0;
    chk("hold_ignores_trig", {27'd0, cap_data, cap_valid}, {27'd0, 4'h3, 1'b1});
    cap_ack = 1'b1; tick(); cap_ack = 1'b0;
    chk("ack_release", {30'd0, busy, cap_valid}, 32'd0);

    // dly=0: capture at t+1
    load_cfg(mk_cfg(4'd0, 1'b0, 3'd0, 3'd1));
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; obs_bus = 32'h0000_0060; tick(); trig = 1'b0;
    chk("dly0_after_t", {31'd0, cap_valid}, 32'd0);
    tick();
    chk("dly0_capture", {27'd0, cap_data, cap_valid}, {27'd0, 4'h6, 1'b1});
    cap_ack = 1'b1; tick(); cap_ack = 1'b0;

    // arm and trig together in IDLE: only ARMED entered
    arm = 1'b1; trig = 1'b1; tick(); arm = 1'b0; trig = 1'b0;
    tick(); tick();
    chk("arm_trig_same", {30'd0, busy, cap_valid}, 32'h2);
    trig = 1'b1; tick(); trig = 1'b0; tick();
    cap_ack = 1'b1; tick(); cap_ack = 1'b0;
    chk("arm_trig_cleanup", {30'd0, busy, cap_valid}, 32'd0);

    // Maximum delay: dly=15 captures at t+16
    load_cfg(mk_cfg(4'd15, 1'b0, 3'd0, 3'd1));
    obs_bus = 32'h0000_00B0;
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("dly15_t15", {31'd0, cap_valid}, 32'd0);
    tick();
    chk("dly15_t16", {27'd0, cap_data, cap_valid}, {27'd0, 4'hB, 1'b1});
    cap_ack = 1'b1; tick(); cap_ack = 1'b0;
`else
    // Capture engine absent: controls have no effect
    arm = 1'b1; trig = 1'b1; cap_ack = 1'b1;
    tick(); tick(); tick();
    arm = 1'b0; trig = 1'b0; cap_ack = 1'b0;
    chk("nocap_outputs", {27'd0, cap_data, cap_valid}, 32'd0);
    chk("nocap_busy", {31'd0, busy}, 32'd0);
`endif

    // Asynchronous reset mid-operation (during DELAY when capture is built)
    func_bus = 32'h7654_3210;
    inj_data = 4'h9;
    obs_bus  = 32'h0000_0020;
    load_cfg(mk_cfg(4'd15, 1'b1, 3'd0, 3'd1));
    #1;
    chk("pre_rst_inj", inj_bus, 32'h7654_3219);
    chk("pre_rst_cfg_out", {31'd0, cfg_out}, 32'd1);
    arm = 1'b1; tick(); arm = 1'b0;
    trig = 1'b1; tick(); trig = 1'b0;
    tick(); tick();
`ifdef TAP_CAPTURE_EN
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_flags", {29'd0, cfg_out, cap_valid, busy}, 32'd0);
    chk("rst_async_inj", inj_bus, 32'h7654_3210);
    chk("rst_async_obs", {28'd0, obs_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
